// File: rtl/universal_shift_reg.sv
// universal_shift_reg: WIDTH-bit hold/shift/rotate/load register with multi-step shifts under valid/ready.
// Optional USR_ZERO_FLAG_EN adds a combinational zero output.
module universal_shift_reg #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [2:0]       mode,
   input  logic [CNT_W-1:0] shamt,
   input  logic [WIDTH-1:0] d,
   input  logic             ssr,
   input  logic             ssl,
   output logic [WIDTH-1:0] q,
   output logic             sout,
   output logic             busy,
`ifdef USR_ZERO_FLAG_EN
   output logic             zero,
`endif
   output logic             done
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           state;
   logic [2:0]       mode_r;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] q_nx;
   logic             sout_nx;
   logic             is_shift;
   assign op_ready = state == IDLE;
   assign busy     = state != IDLE;
   assign done     = state == DONE;
   assign is_shift = mode inside {3'b001, 3'b010, 3'b100, 3'b101, 3'b110};
`ifdef USR_ZERO_FLAG_EN
   assign zero = q == '0;
`endif
   // one step of the latched mode; serial inputs are taken live
   always_comb begin
      q_nx    = q;
      sout_nx = sout;
      case (mode_r)
         3'b001: begin q_nx = {ssr, q[WIDTH-1:1]};      sout_nx = q[0];       end
         3'b010: begin q_nx = {q[WIDTH-2:0], ssl};      sout_nx = q[WIDTH-1]; end
         3'b100: begin q_nx = {q[0], q[WIDTH-1:1]};     sout_nx = q[0];       end
         3'b101: begin q_nx = {q[WIDTH-2:0], q[WIDTH-1]}; sout_nx = q[WIDTH-1]; end
         3'b110: begin q_nx = {q[WIDTH-1], q[WIDTH-1:1]}; sout_nx = q[0];     end
         default: ;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         q      <= '0;
         sout   <= 1'b0;
         mode_r <= '0;
         cnt    <= '0;
      end else begin
         case (state)
            IDLE: if (op_valid) begin
               mode_r <= mode;
               cnt    <= shamt;
               if (mode == 3'b011) q <= d;
               state  <= (is_shift && shamt != '0) ? RUN : DONE;
            end
            RUN: begin
               q     <= q_nx;
               sout  <= sout_nx;
               cnt   <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) state <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
